// File: rtl/bb8_pkg.sv
// rtl/bb8_pkg.sv - shared types and constants for the BLE command path
// Holds the gain type, frame constants, FSM state enums and the frame acceptance rule.
package bb8_pkg;

  typedef logic signed [8:0] gain_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    CMD_PITCH_KP = 4'd0,
    CMD_PITCH_KI = 4'd1,
    CMD_PITCH_KD = 4'd2,
    CMD_YAW_KP   = 4'd3,
    CMD_YAW_KI   = 4'd4,
    CMD_YAW_KD   = 4'd5,
    CMD_SET_PITCH = 4'd6,
    CMD_SET_YAW  = 4'd7,
    CMD_RUN_EN   = 4'd8
  } cmd_id_t;

  typedef enum logic [2:0] {
    PS_SYNC,
    PS_ID,
    PS_HI,
    PS_LO,
    PS_CHK
  } parser_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // run_en frames carry a plain bit, so their HI byte must be exactly zero.
  function automatic logic frame_accept(input logic [7:0] id, input logic [7:0] hi,
                                        input logic [7:0] lo, input logic [7:0] chk);
    logic hi_ok;
    if (id > {4'h0, CMD_RUN_EN}) return 1'b0;
    hi_ok = (id == {4'h0, CMD_RUN_EN}) ? (hi == 8'h00) : (hi[7:1] == {7{hi[0]}});
    return hi_ok && (chk == (id ^ hi ^ lo));
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with start-bit glitch rejection
// Samples mid-bit; a low stop bit reports a framing error and waits for the line to idle.
module uart_rx_byte
  import bb8_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            meta_q, sync_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= uart_rx;
      sync_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = RX_STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sync_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (sync_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign byte_ferr  = ferr_q;

endmodule

// File: rtl/ble_cmd_rx.sv
// rtl/ble_cmd_rx.sv - BLE UART command frame decoder driving PID gains, setpoints and run_en
// Frames are A5 ID HI LO CHK; an inter-byte idle timeout aborts a partial frame.
module ble_cmd_rx
  import bb8_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  uart_rx,
  output gain_t pitch_kP,
  output gain_t pitch_kI,
  output gain_t pitch_kD,
  output gain_t yaw_kP,
  output gain_t yaw_kI,
  output gain_t yaw_kD,
  output gain_t set_pitch,
  output gain_t set_yaw,
  output logic  run_en,
  output logic  frame_ok,
  output logic  frame_err
);

  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  logic       byte_valid, byte_ferr;
  logic [7:0] byte_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ferr  (byte_ferr)
  );

  parser_state_t state_q, state_d;
  logic [7:0]    id_q, id_d, hi_q, hi_d, lo_q, lo_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ok_q, ok_d, err_q, err_d;
  logic          wr_en;
  gain_t         gain_q [0:7];
  logic          run_en_q;
  gain_t         value;

  assign value = $signed({hi_q[0], lo_q});

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= PS_SYNC;
      id_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmo_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      run_en_q <= 1'b0;
      for (int i = 0; i < 8; i++) gain_q[i] <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      tmo_q   <= tmo_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      // Only accepted frames reach here, so id_q[3] set means the run_en ID.
      if (wr_en) begin
        if (id_q[3]) run_en_q <= lo_q[0];
        else         gain_q[id_q[2:0]] <= value;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    tmo_d   = tmo_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    if (byte_valid) begin
      tmo_d = '0;
      case (state_q)
        PS_SYNC: if (byte_data == SYNC_BYTE) state_d = PS_ID;
        PS_ID: begin
          id_d    = byte_data;
          state_d = PS_HI;
        end
        PS_HI: begin
          hi_d    = byte_data;
          state_d = PS_LO;
        end
        PS_LO: begin
          lo_d    = byte_data;
          state_d = PS_CHK;
        end
        PS_CHK: begin
          state_d = PS_SYNC;
          if (frame_accept(id_q, hi_q, lo_q, byte_data)) begin
            ok_d  = 1'b1;
            wr_en = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = PS_SYNC;
      endcase
    end else if (state_q != PS_SYNC) begin
      if (byte_ferr || tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = PS_SYNC;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign pitch_kP  = gain_q[0];
  assign pitch_kI  = gain_q[1];
  assign pitch_kD  = gain_q[2];
  assign yaw_kP    = gain_q[3];
  assign yaw_kI    = gain_q[4];
  assign yaw_kD    = gain_q[5];
  assign set_pitch = gain_q[6];
  assign set_yaw   = gain_q[7];
  assign run_en    = run_en_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ble_cmd_rx.sv
// tb/tb_ble_cmd_rx.sv - table-driven bench for ble_cmd_rx at a scaled-down baud rate
// Vectors carry hand-computed results; extra sequences cover timeout, framing error and reset.
module tb_ble_cmd_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TMO    = 300;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic uart_rx = 1'b1;
  logic signed [8:0] pitch_kP, pitch_kI, pitch_kD, yaw_kP, yaw_kI, yaw_kD, set_pitch, set_yaw;
  logic run_en, frame_ok, frame_err;

  ble_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CLKS(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .uart_rx(uart_rx),
    .pitch_kP(pitch_kP), .pitch_kI(pitch_kI), .pitch_kD(pitch_kD),
    .yaw_kP(yaw_kP), .yaw_kI(yaw_kI), .yaw_kD(yaw_kD),
    .set_pitch(set_pitch), .set_yaw(set_yaw), .run_en(run_en),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int ok_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic snap_taken = 1'b0;
  int snap_pitch_kp = -999;
  int exp_regs [0:8];

  always @(negedge clock) begin
    if (frame_ok) begin
      ok_cnt++;
      if (!snap_taken) begin
        snap_taken = 1'b1;
        snap_pitch_kp = int'(pitch_kP);
      end
    end
    if (frame_err) err_cnt++;
    if (frame_ok && frame_err) both_cnt++;
  end

  typedef struct {
    logic [7:0] id, hi, lo, chk;
    int exp_ok;
    int exp_err;
    int sel;
    int exp_val;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int out_val(input int i);
    case (i)
      0: return int'(pitch_kP);
      1: return int'(pitch_kI);
      2: return int'(pitch_kD);
      3: return int'(yaw_kP);
      4: return int'(yaw_kI);
      5: return int'(yaw_kD);
      6: return int'(set_pitch);
      7: return int'(set_yaw);
      default: return int'(run_en);
    endcase
  endfunction

  task automatic check_all_regs(input string tag);
    for (int i = 0; i <= 8; i++)
      check($sformatf("%s_reg%0d", tag, i), out_val(i), exp_regs[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] id, hi, lo, chk);
    send_byte(8'hA5, 1'b1);
    send_byte(id, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
    send_byte(chk, 1'b1);
    repeat (20) @(negedge clock);
  endtask

  int ok0, err0;

  initial begin
    vecs[0]  = '{8'h00, 8'h00, 8'h19, 8'h19, 1, 0, 0, 25};
    vecs[1]  = '{8'h06, 8'hFF, 8'hF6, 8'h0F, 1, 0, 6, -10};
    vecs[2]  = '{8'h06, 8'h01, 8'hF6, 8'hF1, 0, 1, 6, -10};
    vecs[3]  = '{8'h03, 8'h00, 8'h05, 8'h06, 1, 0, 3, 5};
    vecs[4]  = '{8'h03, 8'h00, 8'h05, 8'h00, 0, 1, 3, 5};
    vecs[5]  = '{8'h08, 8'h00, 8'h01, 8'h09, 1, 0, 8, 1};
    vecs[6]  = '{8'h08, 8'h00, 8'h00, 8'h08, 1, 0, 8, 0};
    vecs[7]  = '{8'h09, 8'h00, 8'h00, 8'h09, 0, 1, 8, 0};
    vecs[8]  = '{8'h07, 8'hFF, 8'h00, 8'hF8, 1, 0, 7, -256};
    vecs[9]  = '{8'h02, 8'h00, 8'hFF, 8'hFD, 1, 0, 2, 255};
    vecs[10] = '{8'h05, 8'h00, 8'hA5, 8'hA0, 1, 0, 5, 165};
    vecs[11] = '{8'h08, 8'h01, 8'h01, 8'h08, 0, 1, 8, 0};
    for (int i = 0; i <= 8; i++) exp_regs[i] = 0;

    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check_all_regs("reset");
    check("reset_frame_ok", int'(frame_ok), 0);
    check("reset_frame_err", int'(frame_err), 0);

    for (int v = 0; v < 12; v++) begin
      ok0 = ok_cnt;
      err0 = err_cnt;
      send_frame(vecs[v].id, vecs[v].hi, vecs[v].lo, vecs[v].chk);
      exp_regs[vecs[v].sel] = vecs[v].exp_val;
      check($sformatf("vec%0d_ok_pulses", v), ok_cnt - ok0, vecs[v].exp_ok);
      check($sformatf("vec%0d_err_pulses", v), err_cnt - err0, vecs[v].exp_err);
      check_all_regs($sformatf("vec%0d", v));
    end
    check("first_ok_same_cycle_pitch_kp", snap_pitch_kp, 25);

    // Timeout after a partial frame, then recovery.
    ok0 = ok_cnt;
    err0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (TMO + 50) @(negedge clock);
    check("timeout_err_once", err_cnt - err0, 1);
    repeat (TMO + 50) @(negedge clock);
    check("timeout_no_repeat", err_cnt - err0, 1);
    check("timeout_no_ok", ok_cnt - ok0, 0);
    check_all_regs("timeout");
    send_frame(8'h01, 8'h00, 8'h07, 8'h06);
    exp_regs[1] = 7;
    check("after_timeout_ok", ok_cnt - ok0, 1);
    check_all_regs("after_timeout");

    // Framing error mid-frame, stray byte in SYNC, then a good frame.
    ok0 = ok_cnt;
    err0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (20) @(negedge clock);
    check("ferr_err_once", err_cnt - err0, 1);
    check("ferr_no_ok", ok_cnt - ok0, 0);
    check_all_regs("ferr");
    err0 = err_cnt;
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clock);
    check("stray_sync_no_err", err_cnt - err0, 0);
    send_frame(8'h04, 8'h00, 8'h03, 8'h07);
    exp_regs[4] = 3;
    check("after_ferr_ok", ok_cnt - ok0, 1);
    check("after_ferr_no_err", err_cnt - err0, 0);
    check_all_regs("after_ferr");

    // Reset in the middle of a byte inside a frame discards everything.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    uart_rx = 1'b0;
    repeat (15) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    uart_rx = 1'b1;
    for (int i = 0; i <= 8; i++) exp_regs[i] = 0;
    check_all_regs("midframe_reset");
    check("midframe_reset_ok", int'(frame_ok), 0);
    check("midframe_reset_err", int'(frame_err), 0);
    repeat (3 * CPB) @(negedge clock);
    ok0 = ok_cnt;
    err0 = err_cnt;
    send_byte(8'h19, 1'b1);
    send_byte(8'h19, 1'b1);
    repeat (20) @(negedge clock);
    check("reset_discard_no_ok", ok_cnt - ok0, 0);
    check("reset_discard_no_err", err_cnt - err0, 0);
    check_all_regs("reset_discard");

    check("ok_err_never_together", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
